// File: rtl/miriscv_apb_gpio.sv
// APB GPIO: OUT/DIR registers, 2-flop synchronized inputs, edge interrupts.
// Interrupt logic is built only when MIRISCV_GPIO_IRQ_EN is defined.
module miriscv_apb_gpio #(
  parameter int WAIT_STATES = 1,
  parameter int GPIO_W      = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [11:0]       paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);

  localparam logic [2:0] WS    = 3'(WAIT_STATES);
  localparam logic [9:0] A_IN  = 10'd0;
  localparam logic [9:0] A_OUT = 10'd1;
  localparam logic [9:0] A_DIR = 10'd2;
  localparam logic [9:0] A_IEN = 10'd3;
  localparam logic [9:0] A_STS = 10'd4;
  localparam logic [9:0] A_TYP = 10'd5;

  logic [2:0]        cnt_q, cnt_d;
  logic              access, mapped;
  logic              wr_en, rd_en;
  logic [9:0]        word;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;
  logic [GPIO_W-1:0] en_r, sts_r, typ_r;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign word        = paddr_i[11:2];
  assign wdata       = pwdata_i[GPIO_W-1:0];
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};
  assign gpio_o      = out_q;
  assign gpio_oe_o   = dir_q;

  // Reset gates pready so a held access never completes during reset.
  always_comb begin
    access    = psel_i & penable_i;
    mapped    = (word <= A_TYP);
    pready_o  = arstn_i & access & (cnt_q == WS);
    pslverr_o = pready_o & ~mapped;
    wr_en     = pready_o & pwrite_i & mapped;
    rd_en     = pready_o & ~pwrite_i & mapped;
    cnt_d     = cnt_q;
    if (!psel_i || pready_o) begin
      cnt_d = '0;
    end else if (access) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    sync1_d = gpio_i;
    sync2_d = sync1_q;
    if (wr_en && word == A_OUT) out_d = wdata;
    if (wr_en && word == A_DIR) dir_d = wdata;
  end

  always_comb begin
    rdata = '0;
    case (word)
      A_IN:    rdata = 32'(sync2_q);
      A_OUT:   rdata = 32'(out_q);
      A_DIR:   rdata = 32'(dir_q);
      A_IEN:   rdata = 32'(en_r);
      A_STS:   rdata = 32'(sts_r);
      A_TYP:   rdata = 32'(typ_r);
      default: rdata = '0;
    endcase
    prdata_o = rd_en ? rdata : '0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q   <= '0;
      out_q   <= '0;
      dir_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef MIRISCV_GPIO_IRQ_EN
  logic [GPIO_W-1:0] en_q, en_d;
  logic [GPIO_W-1:0] sts_q, sts_d;
  logic [GPIO_W-1:0] typ_q, typ_d;
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [GPIO_W-1:0] hit;
  logic              arm_q, arm_d;
  logic              irq_q, irq_d;

  // An edge beats a same-cycle W1C clear, so hit is OR-ed in last.
  always_comb begin
    hit = {GPIO_W{arm_q}} &
          ((typ_q & sync2_q & ~prev_q) |
           (~typ_q & ~sync2_q & prev_q));
    en_d   = en_q;
    typ_d  = typ_q;
    sts_d  = sts_q;
    prev_d = sync2_q;
    arm_d  = 1'b1;
    if (wr_en && word == A_IEN) en_d = wdata;
    if (wr_en && word == A_TYP) typ_d = wdata;
    if (wr_en && word == A_STS) sts_d = sts_q & ~wdata;
    sts_d = sts_d | hit;
    irq_d = |(sts_q & en_q);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      en_q   <= '0;
      sts_q  <= '0;
      typ_q  <= '0;
      prev_q <= '0;
      arm_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      sts_q  <= sts_d;
      typ_q  <= typ_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      irq_q  <= irq_d;
    end
  end

  assign en_r  = en_q;
  assign sts_r = sts_q;
  assign typ_r = typ_q;
  assign irq_o = irq_q;
`else
  assign en_r  = '0;
  assign sts_r = '0;
  assign typ_r = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: doc/miriscv_apb_gpio.md
MIRISCV_APB_GPIO -- requirements
Module: miriscv_apb_gpio

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: number of PREADY-low access cycles before completion, legal 0..7.
REQ-002 SHALL have parameter GPIO_W, default 32: number of GPIO pins, legal 1..32.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 psel_i  input  1  APB select.
REQ-006 penable_i  input  1  APB enable; may rise in the same cycle as psel_i.
REQ-007 pwrite_i  input  1  1 = write, 0 = read.
REQ-008 paddr_i  input  12  byte address; bits [1:0] ignored.
REQ-009 pwdata_i  input  32  write data.
REQ-010 prdata_o  output  32  read data, valid only while pready_o=1.
REQ-011 pready_o  output  1  transfer completion.
REQ-012 pslverr_o  output  1  error on unmapped address, valid only while pready_o=1.
REQ-013 gpio_i  input  GPIO_W  asynchronous pin inputs.
REQ-014 gpio_o  output  GPIO_W  pin output values.
REQ-015 gpio_oe_o  output  GPIO_W  per-pin output enable, 1 = drive.
REQ-016 irq_o  output  1  level interrupt, registered.

Function
REQ-017 Register map (offset): 0x00 IN (RO, synchronized pins), 0x04 OUT (RW), 0x08 DIR (RW), 0x0C IRQ_EN (RW), 0x10 IRQ_STATUS (RO, W1C), 0x14 IRQ_TYPE (RW, 1 = rising, 0 = falling); bits above GPIO_W read 0, writes ignored.
REQ-018 Access phase = psel_i & penable_i; a 3-bit wait counter increments each access cycle with pready_o=0 and clears on the pready_o cycle or whenever psel_i=0.
REQ-019 pready_o = access phase & (counter == WAIT_STATES); WAIT_STATES=0 completes in the first access cycle.
REQ-020 Write side effects occur only on the rising edge ending the pready_o cycle, exactly once per transfer; reads have no side effects.
REQ-021 Unmapped offset (>0x14): pslverr_o=1 with pready_o, prdata_o=0, no state change; otherwise pslverr_o=0.
REQ-022 prdata_o SHALL be 0 whenever pready_o=0.
REQ-023 gpio_i SHALL pass through a 2-flop synchronizer; edge detect compares sync stage 2 against its previous value.
REQ-024 Rising edge on pin n with IRQ_TYPE[n]=1, or falling edge with IRQ_TYPE[n]=0, SHALL set IRQ_STATUS[n] regardless of IRQ_EN[n].
REQ-025 W1C write clears IRQ_STATUS bits written as 1; a detected edge in the same cycle SHALL win (bit stays 1).
REQ-026 irq_o registered: next = |(IRQ_STATUS & IRQ_EN), one cycle after status/enable update.
REQ-027 gpio_o = OUT, gpio_oe_o = DIR, directly from registers; pin latency IN = 2 cycles after gpio_i change, edge IRQ_STATUS = 3, irq_o = 4.
REQ-028 psel_i dropping mid-wait SHALL abort the transfer: counter cleared, no side effects.

Reset
REQ-029 arstn_i low SHALL asynchronously clear all registers, synchronizer flops, edge history and wait counter to 0.
REQ-030 During and after reset: pready_o=0, pslverr_o=0, prdata_o=0, gpio_o=0, gpio_oe_o=0, irq_o=0; an in-flight transfer is discarded.
REQ-031 First cycle after reset release SHALL NOT register an edge from the reset-zero history (edge detect enabled from second cycle).

Configuration
REQ-032 Macro MIRISCV_GPIO_IRQ_EN: defined -> REQ-024..026 interrupt logic present.
REQ-033 Undefined -> IRQ_EN, IRQ_STATUS, IRQ_TYPE read 0, writes accepted without error and ignored, irq_o tied 0; register map and pslverr behaviour unchanged.

Verification
REQ-034 WAIT_STATES=1: write 0x04 = 0xA5A5_0001 with psel/penable both high -> pready_o high 2nd access cycle, gpio_o=0xA5A5_0001 next cycle.
REQ-035 Read 0x20 -> pready_o with pslverr_o=1, prdata_o=0, no register changes.
REQ-036 IRQ_TYPE[3]=1, IRQ_EN[3]=1, gpio_i[3] 0->1 -> IRQ_STATUS=0x8 after 3 cycles, irq_o=1 after 4; W1C 0x8 -> irq_o=0 one cycle after clear.
REQ-037 W1C of bit 3 in the same cycle as a new rising edge on pin 3 -> IRQ_STATUS[3] remains 1, irq_o stays 1.
REQ-038 arstn_i low mid-wait of a write to 0x08 = 0xFFFF_FFFF -> gpio_oe_o=0 immediately, pready_o=0, DIR reads 0 after release.
REQ-039 Build without MIRISCV_GPIO_IRQ_EN: write 0x0C = 0xFFFF_FFFF, toggle gpio_i -> read 0x0C = 0, 0x10 = 0, irq_o=0, pslverr_o=0.
